// File: rtl/sysid_ckr_pkg.sv
// Shared types and constants for the sysid boot checker.
package sysid_ckr_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RD_ID,
    ST_WT_ID,
    ST_RD_TS,
    ST_WT_TS,
    ST_DONE
  } ckr_state_e;

  localparam logic SYSID_WORD_ID = 1'b0;
  localparam logic SYSID_WORD_TS = 1'b1;

  localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/sysid_ckr_timer.sv
// Per-phase cycle counter; o_expired flags the last allowed cycle of a phase.
module sysid_ckr_timer
  import sysid_ckr_pkg::*;
#(
  parameter logic [TMR_W-1:0] TERMINAL = '1
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == TERMINAL);

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads sysid ID and timestamp words after reset or on request and
// reports registered match/timeout status.
module sysid_boot_checker
  import sysid_ckr_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1521070873,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  // Counter holds cycles already spent in the phase, so the last cycle is N-1.
  localparam logic [TMR_W-1:0] TC_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  ckr_state_e  r_state;
  ckr_state_e  w_state_nxt;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_captured_id;
  logic [31:0] r_captured_ts;

  logic w_accept;
  logic w_cap_id;
  logic w_cap_ts;
  logic w_expire;
  logic w_expired;
  logic w_in_phase;
  logic w_restart;
  logic w_busy_nxt;

  always_comb begin
    avm_read    = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    avm_address = ((r_state == ST_RD_TS) || (r_state == ST_WT_TS)) ? SYSID_WORD_TS
                                                                    : SYSID_WORD_ID;
  end

  assign w_accept   = avm_read && !avm_waitrequest;
  assign w_in_phase = (r_state == ST_RD_ID) || (r_state == ST_WT_ID) ||
                      (r_state == ST_RD_TS) || (r_state == ST_WT_TS);
  assign w_restart  = (r_state == ST_DONE) && start;
  assign w_busy_nxt = (w_state_nxt == ST_RD_ID) || (w_state_nxt == ST_WT_ID) ||
                      (w_state_nxt == ST_RD_TS) || (w_state_nxt == ST_WT_TS);

  sysid_ckr_timer #(
    .TERMINAL (TC_LAST)
  ) u_timer (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_clear   (!w_in_phase || w_cap_id || w_cap_ts),
    .i_enable  (w_in_phase),
    .o_expired (w_expired)
  );

  // Data arriving on the final allowed cycle still counts as a capture.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_id    = 1'b0;
    w_cap_ts    = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RD_ID;
      ST_RD_ID, ST_WT_ID: begin
        if (((r_state == ST_WT_ID) || w_accept) && avm_readdatavalid) begin
          w_cap_id    = 1'b1;
          w_state_nxt = ST_RD_TS;
        end else if (w_expired) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_accept) begin
          w_state_nxt = ST_WT_ID;
        end
      end
      ST_RD_TS, ST_WT_TS: begin
        if (((r_state == ST_WT_TS) || w_accept) && avm_readdatavalid) begin
          w_cap_ts    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_expired) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_accept) begin
          w_state_nxt = ST_WT_TS;
        end
      end
      ST_DONE: if (start) w_state_nxt = ST_RD_ID;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_BOOT;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_timeout     <= 1'b0;
      r_captured_id <= '0;
      r_captured_ts <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_cap_id) r_captured_id <= avm_readdata;
      if (w_cap_ts) begin
        r_captured_ts <= avm_readdata;
        r_id_ok       <= (r_captured_id == EXPECTED_ID);
        r_ts_ok       <= (avm_readdata == EXPECTED_TS);
        r_timeout     <= 1'b0;
      end else if (w_expire) begin
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b1;
      end else if (w_restart) begin
        r_id_ok   <= 1'b0;
        r_ts_ok   <= 1'b0;
        r_timeout <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign captured_id = r_captured_id;
  assign captured_ts = r_captured_ts;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker with a small configurable Avalon slave.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1521070873;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] captured_id, captured_ts;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cfg_id = EXP_ID;
  logic [31:0] cfg_ts = EXP_TS;
  logic [31:0] inj_data = '0;
  int          cfg_wait = 0;
  int          cfg_lat = 0;
  bit          cfg_silent_ts = 1'b0;
  bit          cfg_inject = 1'b0;
  int          stall_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data = '0;
  logic [3:0]  exp_tl [0:11];

  sysid_boot_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout           (timeout),
    .captured_id       (captured_id),
    .captured_ts       (captured_ts)
  );

  always #5 clock = ~clock;

  // Slave responses are set up on the falling edge for the next rising edge.
  always @(negedge clock) begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'hDEAD_BEEF;
    if (!reset_n) begin
      stall_cnt = 0;
      rsp_cnt   = 0;
    end else if (cfg_inject) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = inj_data;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rsp_data;
      end
    end else if (avm_read) begin
      if (stall_cnt < cfg_wait) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        stall_cnt = 0;
        if (!(avm_address && cfg_silent_ts)) begin
          if (cfg_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = avm_address ? cfg_ts : cfg_id;
          end else begin
            rsp_cnt  = cfg_lat;
            rsp_data = avm_address ? cfg_ts : cfg_id;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic run_until_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    step();
    step();
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_id_ok", {31'b0, id_ok}, 32'd0);
    check_eq("rst_ts_ok", {31'b0, ts_ok}, 32'd0);
    check_eq("rst_timeout", {31'b0, timeout}, 32'd0);
    check_eq("rst_read", {31'b0, avm_read}, 32'd0);
    check_eq("rst_addr", {31'b0, avm_address}, 32'd0);
    check_eq("rst_cap_id", captured_id, 32'd0);
    check_eq("rst_cap_ts", captured_ts, 32'd0);

    // {busy, done, avm_read, avm_address} seen at edges 0..3, zero-wait slave
    reset_n = 1'b1;
    exp_tl = '{4'b0000, 4'b1010, 4'b1011, 4'b0100,
               4'b0000, 4'b0000, 4'b0000, 4'b0000,
               4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("nom_edge%0d", k), {28'b0, busy, done, avm_read, avm_address}, {28'b0, exp_tl[k]});
      if (k < 3) step();
    end
    check_eq("nom_id_ok", {31'b0, id_ok}, 32'd1);
    check_eq("nom_ts_ok", {31'b0, ts_ok}, 32'd1);
    check_eq("nom_timeout", {31'b0, timeout}, 32'd0);
    check_eq("nom_cap_id", captured_id, EXP_ID);
    check_eq("nom_cap_ts", captured_ts, EXP_TS);

    // start during RD_ID must not restart the sequence
    do_reset();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("ign_addr", {31'b0, avm_address}, 32'd1);
    run_until_done(20, n);
    check_eq("ign_done_edge", n, 32'd1);
    check_eq("ign_id_ok", {31'b0, id_ok}, 32'd1);

    // wrong ID
    cfg_id = 32'h0000_0001;
    do_reset();
    run_until_done(20, n);
    check_eq("bad_done_edge", n, 32'd3);
    check_eq("bad_id_ok", {31'b0, id_ok}, 32'd0);
    check_eq("bad_ts_ok", {31'b0, ts_ok}, 32'd1);
    check_eq("bad_cap_id", captured_id, 32'h0000_0001);
    cfg_id = EXP_ID;

    // 3 stall cycles per command, data one cycle after accept
    cfg_wait = 3;
    cfg_lat  = 1;
    do_reset();
    exp_tl = '{4'b0000, 4'b1010, 4'b1010, 4'b1010,
               4'b1010, 4'b1000, 4'b1011, 4'b1011,
               4'b1011, 4'b1011, 4'b1001, 4'b0100};
    for (int k = 0; k < 12; k++) begin
      check_eq($sformatf("wait_edge%0d", k), {28'b0, busy, done, avm_read, avm_address}, {28'b0, exp_tl[k]});
      if (k < 11) step();
    end
    check_eq("wait_id_ok", {31'b0, id_ok}, 32'd1);
    check_eq("wait_ts_ok", {31'b0, ts_ok}, 32'd1);
    cfg_wait = 0;
    cfg_lat  = 0;

    // timestamp never answered: 8 cycles in the TS phase then timeout
    cfg_silent_ts = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("to_clr_done", {31'b0, done}, 32'd0);
    check_eq("to_clr_id_ok", {31'b0, id_ok}, 32'd0);
    check_eq("to_clr_ts_ok", {31'b0, ts_ok}, 32'd0);
    check_eq("to_read", {30'b0, avm_read, avm_address}, 32'd2);
    run_until_done(30, n);
    check_eq("to_done_edge", n, 32'd9);
    check_eq("to_timeout", {31'b0, timeout}, 32'd1);
    check_eq("to_id_ok", {31'b0, id_ok}, 32'd0);
    check_eq("to_ts_ok", {31'b0, ts_ok}, 32'd0);
    check_eq("to_read_drop", {30'b0, busy, avm_read}, 32'd0);
    check_eq("to_cap_ts", captured_ts, EXP_TS);

    inj_data   = 32'h1234_5678;
    cfg_inject = 1'b1;
    step();
    cfg_inject = 1'b0;
    step();
    check_eq("late_cap_ts", captured_ts, EXP_TS);
    check_eq("late_cap_id", captured_id, EXP_ID);
    check_eq("late_state", {30'b0, done, timeout}, 32'd3);

    // re-check from DONE restores a clean result
    cfg_silent_ts = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("rr_clr", {28'b0, done, timeout, id_ok, ts_ok}, 32'd0);
    check_eq("rr_busy", {31'b0, busy}, 32'd1);
    run_until_done(20, n);
    check_eq("rr_done_edge", n, 32'd2);
    check_eq("rr_result", {29'b0, id_ok, ts_ok, timeout}, 32'd6);

    // asynchronous reset while waiting for ID data
    cfg_lat = 5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("wt_id_state", {30'b0, busy, avm_read}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_flags", {27'b0, busy, done, id_ok, ts_ok, timeout}, 32'd0);
    check_eq("arst_bus", {30'b0, avm_read, avm_address}, 32'd0);
    check_eq("arst_cap_id", captured_id, 32'd0);
    check_eq("arst_cap_ts", captured_ts, 32'd0);
    cfg_lat = 0;
    step();
    reset_n = 1'b1;
    check_eq("rel_boot", {30'b0, busy, avm_read}, 32'd0);
    step();
    check_eq("rel_rd_id", {29'b0, busy, avm_read, avm_address}, 32'd6);
    run_until_done(20, n);
    check_eq("rel_done_edge", n, 32'd2);
    check_eq("rel_result", {29'b0, id_ok, ts_ok, timeout}, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
